// File: rtl/priority_programmer.sv
// Loads a table of DEPTH priority entries into a peripheral memory over a valid/ready
// initiator port, with optional read-back verification and a handshake timeout.
module priority_programmer #(
    parameter int WIDTH      = 5,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   verify_en_i,
    input  logic [DEPTH*WIDTH-1:0] prio_vector_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   timeout_o,
    output logic [ADDR_WIDTH-1:0]  err_index_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic                   wr_rd_o,
    output logic [WIDTH-1:0]       wr_data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    input  logic [WIDTH-1:0]       rd_data_i
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam int                    NUM_SLOTS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [7:0]            TMO_LIMIT = 8'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [DEPTH*WIDTH-1:0]  prio_q, prio_d;
    logic                    verify_q, verify_d;
    logic                    err_q, err_d;
    logic                    timeout_q, timeout_d;
    logic [ADDR_WIDTH-1:0]   err_index_q, err_index_d;

    logic [WIDTH-1:0]        entry_w [NUM_SLOTS];
    logic [WIDTH-1:0]        cur_entry;
    logic                    active;

    // Slots beyond DEPTH exist only so the full index range maps cleanly; they read as zero.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_entry
            if (gi < DEPTH) begin : g_used
                assign entry_w[gi] = prio_q[gi*WIDTH +: WIDTH];
            end else begin : g_unused
                assign entry_w[gi] = '0;
            end
        end
    endgenerate

    assign cur_entry = entry_w[idx_q];
    assign active    = (state_q == WRITE) || (state_q == READ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            prio_q      <= '0;
            verify_q    <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            prio_q      <= prio_d;
            verify_q    <= verify_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            err_index_q <= err_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        prio_d      = prio_q;
        verify_d    = verify_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        err_index_d = err_index_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    prio_d      = prio_vector_i;
                    verify_d    = verify_en_i;
                    err_d       = 1'b0;
                    timeout_d   = 1'b0;
                    err_index_d = '0;
                    idx_d       = '0;
                    tmo_d       = '0;
                    state_d     = WRITE;
                end
            end
            WRITE, READ: begin
                if (ready_i) begin
                    tmo_d = '0;
                    if ((state_q == READ) && (rd_data_i != cur_entry) && !err_q) begin
                        err_d       = 1'b1;
                        err_index_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ((state_q == WRITE) && verify_q) ? READ : DONE;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end else if ((tmo_q + 8'd1) == TMO_LIMIT) begin
                    // The earliest recorded failure keeps its index.
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    if (!err_q) begin
                        err_index_d = idx_q;
                    end
                    tmo_d   = '0;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = active;
        valid_o     = active;
        done_o      = (state_q == DONE);
        wr_rd_o     = (state_q == WRITE);
        addr_o      = active ? idx_q : '0;
        wr_data_o   = (state_q == WRITE) ? cur_entry : '0;
        err_o       = err_q;
        timeout_o   = timeout_q;
        err_index_o = err_index_q;
    end

endmodule
